// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the unified data/instruction memory port arbiter.
// Holds the datapath widths, the RISC-V load/store funct3 encodings, the
// access-size field decoded from funct3[1:0] and the arbiter state encoding.
package dmem_port_arbiter_pkg;

    localparam int GPR_WIDTH    = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int FUNCT3_WIDTH = 3;

    localparam logic [FUNCT3_WIDTH-1:0] LB_FUN3  = 3'b000;
    localparam logic [FUNCT3_WIDTH-1:0] LH_FUN3  = 3'b001;
    localparam logic [FUNCT3_WIDTH-1:0] LW_FUN3  = 3'b010;
    localparam logic [FUNCT3_WIDTH-1:0] LBU_FUN3 = 3'b100;
    localparam logic [FUNCT3_WIDTH-1:0] LHU_FUN3 = 3'b101;
    localparam logic [FUNCT3_WIDTH-1:0] SB_FUN3  = 3'b000;
    localparam logic [FUNCT3_WIDTH-1:0] SH_FUN3  = 3'b001;
    localparam logic [FUNCT3_WIDTH-1:0] SW_FUN3  = 3'b010;

    // funct3[1:0] carries the access size for both loads and stores;
    // funct3[2] only selects zero extension, which the MEM stage handles.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2,
        ARB_ERR     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane helper for the load/store path.
// Ports:
//   mode          funct3 of the load/store
//   offset        addr[1:0] of the request being granted
//   wdata         right-justified store data
//   rd_offset     addr[1:0] latched with the access now completing
//   rdata_in      word returned by memory
//   be            byte enables for the request
//   wdata_shifted store data moved into its byte lanes
//   misalign      request crosses its natural alignment
//   rdata_shifted read word shifted down so the addressed byte is at bit 0
module lsu_lane_align
    import dmem_port_arbiter_pkg::*;
(
    input  logic [FUNCT3_WIDTH-1:0] mode,
    input  logic [1:0]              offset,
    input  logic [GPR_WIDTH-1:0]    wdata,
    input  logic [1:0]              rd_offset,
    input  logic [DATA_WIDTH-1:0]   rdata_in,
    output logic [3:0]              be,
    output logic [DATA_WIDTH-1:0]   wdata_shifted,
    output logic                    misalign,
    output logic [DATA_WIDTH-1:0]   rdata_shifted
);

    logic [1:0] size;
    logic       unused_sign_bit;

    assign size            = mode[1:0];
    assign unused_sign_bit = mode[2];

    // Any size encoding other than byte/half is handled as a full word,
    // so undefined funct3 values still produce a well-formed access.
    always_comb begin
        be       = 4'b1111;
        misalign = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be       = 4'b0001 << offset;
                misalign = 1'b0;
            end
            SIZE_HALF: begin
                be       = 4'b0011 << offset;
                misalign = offset[0];
            end
            default: begin
                be       = 4'b1111;
                misalign = |offset;
            end
        endcase
    end

    assign wdata_shifted = DATA_WIDTH'(wdata) << {offset, 3'b000};
    assign rdata_shifted = rdata_in >> {rd_offset, 3'b000};

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one memory port between instruction fetch and
// the load/store path. Each access is a single registered transaction;
// load/store gets priority, with a grant-streak counter forcing IF through
// after STARVE_LIMIT consecutive load/store grants while IF waits.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req_i/if_addr_i            IF word-read request (held until done)
//   if_done_o/if_rdata_o          IF completion pulse and fetched word
//   ls_req_i/ls_we_i/ls_mode_i    load/store request, direction, funct3
//   ls_addr_i/ls_wdata_i          byte address and right-justified data
//   ls_done_o/ls_err_o/ls_rdata_o completion pulse, misalign flag, data
//   mem_*                         memory port (req held until mem_ack_i)
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = GPR_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_W-1:0]       if_addr_i,
    output logic                    if_done_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    ls_req_i,
    input  logic                    ls_we_i,
    input  logic [FUNCT3_WIDTH-1:0] ls_mode_i,
    input  logic [ADDR_W-1:0]       ls_addr_i,
    input  logic [GPR_WIDTH-1:0]    ls_wdata_i,
    output logic                    ls_done_o,
    output logic                    ls_err_o,
    output logic [DATA_WIDTH-1:0]   ls_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [3:0]              mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [1:0]            offset_q, offset_d;

    logic                  mem_req_d, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [3:0]            mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  if_done_d, ls_done_d, ls_err_d;
    logic [DATA_WIDTH-1:0] if_rdata_d, ls_rdata_d;

    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic                  al_misalign;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  if_forced;
    logic                  unused_if_lanes;

    // IF fetches are always whole words, so its low address bits are dropped.
    assign unused_if_lanes = ^if_addr_i[1:0];

    assign if_forced = if_req_i && (streak_q == STREAK_W'(STARVE_LIMIT));

    lsu_lane_align u_align (
        .mode          (ls_mode_i),
        .offset        (ls_addr_i[1:0]),
        .wdata         (ls_wdata_i),
        .rd_offset     (offset_q),
        .rdata_in      (mem_rdata_i),
        .be            (al_be),
        .wdata_shifted (al_wdata),
        .misalign      (al_misalign),
        .rdata_shifted (al_rdata)
    );

    // Next-state and next-output logic. Done/err pulses default low every
    // cycle; all other registered outputs hold unless this cycle updates them.
    // A misaligned load/store still counts as a grant for starvation purposes.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        offset_d    = offset_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_be_d    = mem_be_o;
        mem_wdata_d = mem_wdata_o;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        ls_err_d    = 1'b0;
        if_rdata_d  = if_rdata_o;
        ls_rdata_d  = ls_rdata_o;

        case (state_q)
            ARB_IDLE: begin
                if (ls_req_i && !if_forced) begin
                    streak_d = if_req_i ? (streak_q + STREAK_W'(1)) : '0;
                    if (al_misalign) begin
                        state_d = ARB_ERR;
                    end else begin
                        state_d     = ARB_BUSY_LS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ls_we_i;
                        mem_addr_d  = {ls_addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        offset_d    = ls_addr_i[1:0];
                    end
                end else if (if_req_i) begin
                    streak_d    = '0;
                    state_d     = ARB_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {if_addr_i[ADDR_W-1:2], 2'b00};
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = '0;
                    offset_d    = 2'b00;
                end
            end
            ARB_BUSY_IF: begin
                if (mem_ack_i) begin
                    state_d    = ARB_IDLE;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata_i;
                end
            end
            ARB_BUSY_LS: begin
                if (mem_ack_i) begin
                    state_d    = ARB_IDLE;
                    mem_req_d  = 1'b0;
                    ls_done_d  = 1'b1;
                    ls_rdata_d = mem_we_o ? '0 : al_rdata;
                end
            end
            ARB_ERR: begin
                state_d    = ARB_IDLE;
                ls_done_d  = 1'b1;
                ls_err_d   = 1'b1;
                ls_rdata_d = '0;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset abandons any in-flight access:
    // the request drops and no completion is reported for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            offset_q    <= 2'b00;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
            if_done_o   <= 1'b0;
            ls_done_o   <= 1'b0;
            ls_err_o    <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            offset_q    <= offset_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_be_o    <= mem_be_d;
            mem_wdata_o <= mem_wdata_d;
            if_done_o   <= if_done_d;
            ls_done_o   <= ls_done_d;
            ls_err_o    <= ls_err_d;
            if_rdata_o  <= if_rdata_d;
            ls_rdata_o  <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge; expected completions are queued when a
// request is driven and popped when the done pulse is due.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i;
    logic        ls_we_i;
    logic [2:0]  ls_mode_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        ls_done_o;
    logic        ls_err_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit          is_if;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } lane_t;

    dmem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_done_o   (if_done_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_mode_i   (ls_mode_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_done_o   (ls_done_o),
        .ls_err_o    (ls_err_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polls mem_req_o at falling edges, starting with the current one.
    task automatic wait_mem_req(input int budget, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i <= budget; i++) begin
            if (mem_req_o === 1'b1) begin
                seen   = 1'b1;
                waited = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Acknowledges after lat cycles; returns at the cycle after the ack.
    task automatic applyStimulus_ack(input int lat, input logic [31:0] rd);
        repeat (lat) @(negedge clk);
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        @(negedge clk);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        if_req_i  = 1'b0;
        if_addr_i = 32'h0;
        ls_req_i  = 1'b0;
        ls_we_i   = 1'b0;
        ls_mode_i = 3'b000;
        ls_addr_i = 32'h0;
        ls_wdata_i = 32'h0;
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem_ctrl: got %b required 000000", {mem_req_o, mem_we_o, mem_be_o});
        end
        tests_run++;
        if ({if_done_o, ls_done_o, ls_err_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %b required 000", {if_done_o, ls_done_o, ls_err_o});
        end
        tests_run++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o} !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h required 0", {mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o});
        end
        rst = 1'b0;
        @(negedge clk);
        // An ack with nothing outstanding must be ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555AAAA;
        @(negedge clk);
        mem_ack_i   = 1'b0;
        tests_run++;
        if ({if_done_o, ls_done_o, mem_req_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_ack_ignored: got %b required 000", {if_done_o, ls_done_o, mem_req_o});
        end
    endtask

    task automatic test_if_only();
        bit   seen;
        int   waited;
        exp_t e;
        $display("[TB] IF-only fetch");
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        sb.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
        wait_mem_req(10, seen, waited);
        tests_run++;
        if (!seen || waited != 1) begin
            tests_failed++;
            $display("[TB] FAIL if_req_latency: got seen=%0d waited=%0d required 1 cycle", seen, waited);
            return;
        end
        tests_run++;
        if ({mem_we_o, mem_addr_o, mem_be_o} !== {1'b0, 32'h100, 4'b1111}) begin
            tests_failed++;
            $display("[TB] FAIL if_fields: got we=%b addr=%h be=%b required 0/00000100/1111", mem_we_o, mem_addr_o, mem_be_o);
        end
        applyStimulus_ack(3, 32'hCAFEF00D);
        if_req_i = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if ({if_done_o, ls_done_o, if_rdata_o, mem_req_o} !== {e.is_if, ~e.is_if, e.rdata, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL if_done: got if_done=%b ls_done=%b rdata=%h req=%b required 1/0/%h/0", if_done_o, ls_done_o, if_rdata_o, mem_req_o, e.rdata);
        end
        @(negedge clk);
        tests_run++;
        if ({if_done_o, mem_req_o} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL if_done_pulse: got done=%b req=%b required 0/0", if_done_o, mem_req_o);
        end
    endtask

    task automatic test_lane_table();
        lane_t tbl[7];
        bit    seen;
        int    waited;
        exp_t  e;
        $display("[TB] load/store lane table");
        tbl[0] = '{1'b1, SB_FUN3,  32'h203, 32'h000000AB, 32'h12345678, 4'b1000, 32'hAB000000, 32'h0};
        tbl[1] = '{1'b0, LH_FUN3,  32'h202, 32'h0,        32'hBEEF1234, 4'b1100, 32'h0,        32'h0000BEEF};
        tbl[2] = '{1'b0, LBU_FUN3, 32'h101, 32'h0,        32'h11223344, 4'b0010, 32'h0,        32'h00112233};
        tbl[3] = '{1'b1, SH_FUN3,  32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 4'b1100, 32'hABCD0000, 32'h0};
        tbl[4] = '{1'b0, LW_FUN3,  32'h304, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF};
        tbl[5] = '{1'b1, SW_FUN3,  32'h308, 32'h13579BDF, 32'h0,        4'b1111, 32'h13579BDF, 32'h0};
        tbl[6] = '{1'b0, LB_FUN3,  32'h200, 32'h0,        32'h000000FF, 4'b0001, 32'h0,        32'h000000FF};
        for (int i = 0; i < 7; i++) begin
            ls_req_i   = 1'b1;
            ls_we_i    = tbl[i].we;
            ls_mode_i  = tbl[i].mode;
            ls_addr_i  = tbl[i].addr;
            ls_wdata_i = tbl[i].wdata;
            sb.push_back('{1'b0, 1'b0, tbl[i].exp_rdata});
            wait_mem_req(10, seen, waited);
            tests_run++;
            if (!seen || waited != 1) begin
                tests_failed++;
                $display("[TB] FAIL ls_req_latency[%0d]: got seen=%0d waited=%0d required 1 cycle", i, seen, waited);
                ls_req_i = 1'b0;
                void'(sb.pop_front());
                return;
            end
            tests_run++;
            if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !==
                {tbl[i].we, {tbl[i].addr[31:2], 2'b00}, tbl[i].be, tbl[i].exp_wdata}) begin
                tests_failed++;
                $display("[TB] FAIL ls_fields[%0d]: got we=%b addr=%h be=%b wdata=%h required we=%b addr=%h be=%b wdata=%h",
                         i, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                         tbl[i].we, {tbl[i].addr[31:2], 2'b00}, tbl[i].be, tbl[i].exp_wdata);
            end
            applyStimulus_ack(2, tbl[i].rdata);
            ls_req_i = 1'b0;
            e = sb.pop_front();
            tests_run++;
            if ({ls_done_o, ls_err_o, if_done_o, ls_rdata_o} !== {1'b1, e.err, 1'b0, e.rdata}) begin
                tests_failed++;
                $display("[TB] FAIL ls_done[%0d]: got done=%b err=%b if_done=%b rdata=%h required 1/%b/0/%h",
                         i, ls_done_o, ls_err_o, if_done_o, ls_rdata_o, e.err, e.rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_misaligned();
        lane_t tbl[3];
        exp_t  e;
        bit    req_seen;
        $display("[TB] misaligned accesses");
        tbl[0] = '{1'b0, LW_FUN3, 32'h301, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, LH_FUN3, 32'h201, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b1, SH_FUN3, 32'h203, 32'h1, 32'h0, 4'b0, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            ls_req_i   = 1'b1;
            ls_we_i    = tbl[i].we;
            ls_mode_i  = tbl[i].mode;
            ls_addr_i  = tbl[i].addr;
            ls_wdata_i = tbl[i].wdata;
            sb.push_back('{1'b0, 1'b1, 32'h0});
            @(negedge clk);
            req_seen = mem_req_o;
            tests_run++;
            if (ls_done_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL misalign_early_done[%0d]: got %b required 0", i, ls_done_o);
            end
            @(negedge clk);
            req_seen = req_seen | mem_req_o;
            ls_req_i = 1'b0;
            e = sb.pop_front();
            tests_run++;
            if ({ls_done_o, ls_err_o, ls_rdata_o} !== {1'b1, e.err, e.rdata}) begin
                tests_failed++;
                $display("[TB] FAIL misalign_done[%0d]: got done=%b err=%b rdata=%h required 1/1/0", i, ls_done_o, ls_err_o, ls_rdata_o);
            end
            @(negedge clk);
            req_seen = req_seen | mem_req_o;
            tests_run++;
            if ({req_seen, ls_done_o, ls_err_o} !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL misalign_quiet[%0d]: got req_seen=%b done=%b err=%b required 000", i, req_seen, ls_done_o, ls_err_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   seen;
        int   waited;
        exp_t e;
        $display("[TB] back-to-back loads and dropped request");
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_mode_i = LB_FUN3;
        for (int i = 0; i < 3; i++) begin
            ls_addr_i = 32'h600 + i;
            sb.push_back('{1'b0, 1'b0, 32'h000000C0 + i});
            wait_mem_req(10, seen, waited);
            tests_run++;
            if (!seen || waited != 1 || mem_be_o !== (4'b0001 << i)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_grant[%0d]: got seen=%0d waited=%0d be=%b required 1 cycle be=%b", i, seen, waited, mem_be_o, 4'b0001 << i);
                ls_req_i = 1'b0;
                void'(sb.pop_front());
                return;
            end
            applyStimulus_ack(0, (32'h000000C0 + i) << (8 * i));
            if (i == 2) ls_req_i = 1'b0;
            e = sb.pop_front();
            tests_run++;
            if ({ls_done_o, ls_rdata_o} !== {1'b1, e.rdata}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_done[%0d]: got done=%b rdata=%h required 1/%h", i, ls_done_o, ls_rdata_o, e.rdata);
            end
        end
        @(negedge clk);
        // An IF request that drops while its access is outstanding still completes.
        if_req_i  = 1'b1;
        if_addr_i = 32'h10C;
        sb.push_back('{1'b1, 1'b0, 32'h0BADC0DE});
        wait_mem_req(10, seen, waited);
        if_req_i = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL drop_req_grant: got no mem_req_o required a grant");
            void'(sb.pop_front());
            return;
        end
        applyStimulus_ack(2, 32'h0BADC0DE);
        e = sb.pop_front();
        tests_run++;
        if ({if_done_o, if_rdata_o} !== {1'b1, e.rdata}) begin
            tests_failed++;
            $display("[TB] FAIL drop_req_done: got done=%b rdata=%h required 1/%h", if_done_o, if_rdata_o, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        bit exp_if[10];
        bit seen;
        int waited;
        bit got_if;
        $display("[TB] IF starvation bound");
        for (int i = 0; i < 10; i++) exp_if[i] = (i == 4) || (i == 9);
        if_req_i   = 1'b1;
        if_addr_i  = 32'h800;
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_mode_i  = SW_FUN3;
        ls_addr_i  = 32'h400;
        ls_wdata_i = 32'h00C0FFEE;
        for (int i = 0; i < 10; i++) begin
            wait_mem_req(10, seen, waited);
            if (!seen) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL starve_grant[%0d]: got no mem_req_o required a grant", i);
                break;
            end
            got_if = (mem_addr_o === 32'h800);
            tests_run++;
            if (got_if !== exp_if[i]) begin
                tests_failed++;
                $display("[TB] FAIL starve_order[%0d]: got is_if=%0d required is_if=%0d", i, got_if, exp_if[i]);
            end
            applyStimulus_ack(0, 32'h0);
            if (i == 9) begin
                if_req_i = 1'b0;
                ls_req_i = 1'b0;
            end
            tests_run++;
            if ({if_done_o, ls_done_o} !== (exp_if[i] ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("[TB] FAIL starve_done[%0d]: got if/ls=%b required %b", i, {if_done_o, ls_done_o}, exp_if[i] ? 2'b10 : 2'b01);
            end
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit   seen;
        int   waited;
        exp_t e;
        $display("[TB] reset during transaction");
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_mode_i = LW_FUN3;
        ls_addr_i = 32'h500;
        wait_mem_req(10, seen, waited);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_grant: got no mem_req_o required a grant");
            ls_req_i = 1'b0;
            return;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_req: got %b required 0", mem_req_o);
        end
        rst       = 1'b0;
        ls_req_i  = 1'b0;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h77777777;
        @(negedge clk);
        mem_ack_i = 1'b0;
        tests_run++;
        if ({ls_done_o, if_done_o, ls_err_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL rst_late_ack: got ls/if/err=%b required 000", {ls_done_o, if_done_o, ls_err_o});
        end
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h107;
        sb.push_back('{1'b1, 1'b0, 32'h600DF00D});
        wait_mem_req(10, seen, waited);
        tests_run++;
        if (!seen || mem_addr_o !== 32'h104 || mem_be_o !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL rst_after_grant: got seen=%0d addr=%h be=%b required 1/00000104/1111", seen, mem_addr_o, mem_be_o);
            if_req_i = 1'b0;
            void'(sb.pop_front());
            return;
        end
        applyStimulus_ack(1, 32'h600DF00D);
        if_req_i = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if ({if_done_o, if_rdata_o} !== {1'b1, e.rdata}) begin
            tests_failed++;
            $display("[TB] FAIL rst_after_done: got done=%b rdata=%h required 1/%h", if_done_o, if_rdata_o, e.rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_lane_table();
        test_misaligned();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single unified memory port between instruction fetch (IF) and the load/store path (MEM stage, ahead of its data cache).
Sequences each access as one memory transaction and generates byte enables and store-lane shifting from funct3 and address bits [1:0].
Returns load data right-justified; the MEM stage still performs sign or zero extension.
Flags misaligned accesses without touching memory, and bounds IF starvation with a grant-streak counter.

Parameters:
ADDR_W, `GPR_WIDTH (32), address width of both requesters and the memory port.
STARVE_LIMIT, 4, maximum consecutive MEM grants while IF is pending before IF is forced through.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
if_req_i  in  1  IF word-read request; held until if_done_o
if_addr_i  in  ADDR_W  IF address
if_done_o  out  1  one-cycle pulse; if_rdata_o valid
if_rdata_o  out  `DATA_WIDTH  fetched word
ls_req_i  in  1  load/store request; held until ls_done_o
ls_we_i  in  1  1 = store, 0 = load
ls_mode_i  in  `funct3_width  funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW)
ls_addr_i  in  ADDR_W  byte address
ls_wdata_i  in  `GPR_WIDTH  store data, right-justified
ls_done_o  out  1  one-cycle pulse; access complete
ls_err_o  out  1  valid with ls_done_o; misaligned, no memory access made
ls_rdata_o  out  `DATA_WIDTH  load data shifted down by addr[1:0]
mem_req_o  out  1  memory request; held until mem_ack_i
mem_we_o  out  1  write
mem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_be_o  out  4  byte enables
mem_wdata_o  out  `DATA_WIDTH  lane-shifted store data
mem_ack_i  in  1  one-cycle completion; mem_rdata_i valid
mem_rdata_i  in  `DATA_WIDTH  read word

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_LS, ERR. All outputs are registered.
- Reset: state IDLE; every output 0; streak counter 0. Reset mid-transaction drops mem_req_o in the next cycle and abandons the access; no done pulse is produced.
- IDLE arbitration: ls_req_i wins over if_req_i, unless streak == STARVE_LIMIT and if_req_i = 1, in which case IF wins.
  - Streak increments on each LS grant made while if_req_i = 1.
  - Streak clears on any IF grant, and on any LS grant made while if_req_i = 0.
- LS alignment check at grant:
  - H modes (LH/LHU/SH) with addr[0] != 0 are misaligned.
  - W modes (LW/SW) with addr[1:0] != 0 are misaligned.
  - Misaligned: go to ERR with no mem_req_o; next cycle ls_done_o = 1, ls_err_o = 1; return to IDLE.
- Byte enables:
  - B modes: 1 << addr[1:0].
  - H modes: 4'b0011 << addr[1:0].
  - W modes: 4'b1111.
  - Loads also drive mem_be_o. mem_wdata_o = ls_wdata_i << (8*addr[1:0]).
- Grant at cycle N: mem_* fields are latched and mem_req_o = 1 from cycle N+1 until the cycle of mem_ack_i inclusive. It is deasserted in the cycle after the ack.
- Ack at cycle M: the matching done pulse and rdata appear at cycle M+1; the FSM is in IDLE at M+1.
  - A new grant can occur at M+1, giving mem_req_o again at M+2. Back-to-back throughput is therefore one access per 2 cycles plus memory latency.
- ls_rdata_o = mem_rdata_i >> (8*addr[1:0]), using the latched addr. Write completions return ls_rdata_o = 0.
- IF requests are always word reads: be = 4'b1111. if_addr_i[1:0] is ignored, with no error.
- mem_ack_i while in IDLE or ERR is ignored.
- A request deasserted while busy does not cancel the access; its done pulse is still issued.
- ls_err_o is 0 whenever ls_done_o is 0.
- Done outputs never pulse in the same cycle for both requesters.

Decomposition:
- Shared package/header: existing `LB_FUN3…`SW_FUN3, `GPR_WIDTH, `DATA_WIDTH, `funct3_width; new state encodings `ARB_IDLE/`ARB_BUSY_IF/`ARB_BUSY_LS/`ARB_ERR.
- One sub-module: lsu_lane_align, combinational. It takes mode and addr[1:0] and produces be, shifted wdata and misalign; it also performs the rdata down-shift.

Test Plan:
- IF only: if_addr=0x100, ack 3 cycles after mem_req_o -> mem_addr_o=0x100, be=1111, if_done_o one cycle after ack with if_rdata_o=mem_rdata_i.
- SB at 0x203, wdata=0xAB -> mem_addr_o=0x200, be=1000, mem_wdata_o=0xAB000000, ls_done_o=1, ls_err_o=0.
- LH at 0x202, mem_rdata=0xBEEF1234 -> be=1100, ls_rdata_o=0x0000BEEF.
- LW at 0x301 -> no mem_req_o ever; ls_done_o=ls_err_o=1 exactly 2 cycles after request.
- Both requesters permanently asserted, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,…; the IF grant occurs within 5 grants.
- rst asserted while mem_req_o=1 -> mem_req_o=0 the next cycle; a late ack produces no done pulse; the next request is served normally.
